// File: rtl/usb_dma_arbiter_pkg.sv
// Shared definitions for the USB DMA / CPU memory arbiter: state encoding,
// bus width, IO window position and write strobe constants.
package usb_dma_arbiter_pkg;

    localparam int L = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DMA  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    // DMA transfers are word-wide, so the byte-lane bit of its address is dropped
    localparam logic [L-1:0] WORD_MASK = ~L'(1);

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BOTH = 2'b11;

endpackage

// File: rtl/usb_dma_arbiter_if.sv
// Bundles the CPU, USB DMA and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface usb_dma_arbiter_if;
    import usb_dma_arbiter_pkg::*;

    logic [L-1:0] cpu_addr;
    logic         cpu_r;
    logic [1:0]   cpu_w;
    logic [L-1:0] cpu_dout;
    logic         cpu_stall;

    logic [L-1:0] dma_addr;
    logic         dma_reqr;
    logic         dma_reqw;
    logic [L-1:0] dma_dout;
    logic [L-1:0] dma_din;
    logic         dma_ack;

    logic         mem_sel;
    logic [L-1:0] mem_addr;
    logic         mem_r;
    logic [1:0]   mem_w;
    logic [L-1:0] mem_wdata;
    logic [L-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_r, cpu_w, cpu_dout,
        input  dma_addr, dma_reqr, dma_reqw, dma_dout,
        input  mem_rdata,
        output cpu_stall, dma_din, dma_ack,
        output mem_sel, mem_addr, mem_r, mem_w, mem_wdata
    );

    modport master (
        output cpu_addr, cpu_r, cpu_w, cpu_dout,
        output dma_addr, dma_reqr, dma_reqw, dma_dout,
        output mem_rdata,
        input  cpu_stall, dma_din, dma_ack,
        input  mem_sel, mem_addr, mem_r, mem_w, mem_wdata
    );

endinterface

// File: rtl/usb_dma_arbiter_starve_counter.sv
// Saturating count of cycles a pending DMA request has lost to a busy CPU.
// at_max tells the arbiter the CPU must now yield.
module dma_starve_counter #(
    parameter int MAXWAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    // A zero-wait configuration still needs a one-bit register to stay legal
    localparam int SW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;

    logic [SW-1:0] count;

    assign at_max = (count == SW'(MAXWAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/usb_dma_arbiter.sv
// Memory-side responder for the USB DMA port: shares one 16-bit memory with
// the CPU, serving each DMA request once and stalling the CPU only on starvation.
module usb_dma_arbiter
    import usb_dma_arbiter_pkg::*;
#(
    parameter int MAXWAIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    usb_dma_arbiter_if.slave   bus
);

    arb_state_t   state;
    logic         ack_q;
    logic [L-1:0] din_q;

    logic io_win;
    logic cpu_busy;
    logic dma_req;
    logic at_max;
    logic starve_clear;
    logic starve_inc;

    // Addresses FFF8..FFFF belong to on-chip IO, never to shared memory
    assign io_win   = &bus.cpu_addr[L-1:3];
    assign cpu_busy = (bus.cpu_r | (|bus.cpu_w)) & ~io_win;
    assign dma_req  = bus.dma_reqr | bus.dma_reqw;

    assign starve_clear = (state == ST_DMA);
    assign starve_inc   = (state == ST_IDLE) && dma_req && cpu_busy;

    dma_starve_counter #(
        .MAXWAIT (MAXWAIT)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .clear  (starve_clear),
        .inc    (starve_inc),
        .at_max (at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ack_q <= 1'b0;
            din_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dma_req && (!cpu_busy || at_max)) begin
                        state <= ST_DMA;
                    end
                end
                ST_DMA: begin
                    // A combined read+write request is served as a write only
                    if (bus.dma_reqr && !bus.dma_reqw) begin
                        din_q <= bus.mem_rdata;
                    end
                    ack_q <= 1'b1;
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dma_ack = ack_q;
    assign bus.dma_din = din_q;

    always_comb begin
        bus.mem_sel   = ~io_win;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_r     = bus.cpu_r;
        bus.mem_w     = bus.cpu_w;
        bus.mem_wdata = bus.cpu_dout;
        bus.cpu_stall = 1'b0;
        if (state == ST_DMA) begin
            bus.mem_sel   = 1'b1;
            bus.mem_addr  = bus.dma_addr & WORD_MASK;
            bus.mem_r     = bus.dma_reqr & ~bus.dma_reqw;
            bus.mem_w     = bus.dma_reqw ? WR_BOTH : WR_NONE;
            bus.mem_wdata = bus.dma_dout;
            bus.cpu_stall = cpu_busy;
        end
        // Reset may cut a DMA write short; make sure nothing reaches memory
        if (reset) begin
            bus.mem_sel = 1'b0;
            bus.mem_r   = 1'b0;
            bus.mem_w   = WR_NONE;
        end
    end

endmodule

// File: tb/tb_usb_dma_arbiter.sv
// Directed bench for usb_dma_arbiter: a word-addressed memory model on the
// memory side, hand-computed expectations for each DMA/CPU scenario.
module tb_usb_dma_arbiter;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   write_count;
    int   wc0;

    logic [15:0] mem [0:32767];

    usb_dma_arbiter_if bus ();

    usb_dma_arbiter #(
        .MAXWAIT (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[15:1]];

    always @(posedge clk) begin
        if (bus.mem_sel && bus.mem_w != 2'b00) begin
            if (bus.mem_w[0]) mem[bus.mem_addr[15:1]][7:0]  = bus.mem_wdata[7:0];
            if (bus.mem_w[1]) mem[bus.mem_addr[15:1]][15:8] = bus.mem_wdata[15:8];
            write_count = write_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one cycle, drive the new inputs just after the edge, then let them settle
    task automatic applyStimulus(input logic [15:0] cpu_addr, input logic cpu_r, input logic [1:0] cpu_w,
                                 input logic [15:0] cpu_dout, input logic [15:0] dma_addr,
                                 input logic reqr, input logic reqw, input logic [15:0] dma_dout);
        @(posedge clk);
        #1;
        bus.cpu_addr = cpu_addr;
        bus.cpu_r    = cpu_r;
        bus.cpu_w    = cpu_w;
        bus.cpu_dout = cpu_dout;
        bus.dma_addr = dma_addr;
        bus.dma_reqr = reqr;
        bus.dma_reqw = reqw;
        bus.dma_dout = dma_dout;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        write_count = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[15'h2B3C] = 16'h1234;
        mem[15'h0080] = 16'hCAFE;
        mem[15'h1000] = 16'h7777;

        reset        = 1'b1;
        bus.cpu_addr = 16'h0000;
        bus.cpu_r    = 1'b0;
        bus.cpu_w    = 2'b00;
        bus.cpu_dout = 16'h0000;
        bus.dma_addr = 16'h0000;
        bus.dma_reqr = 1'b0;
        bus.dma_reqw = 1'b0;
        bus.dma_dout = 16'h0000;
        #2;
        checkOutput("reset ack",   16'(bus.dma_ack),   16'h0);
        checkOutput("reset din",   bus.dma_din,        16'h0000);
        checkOutput("reset stall", 16'(bus.cpu_stall), 16'h0);
        checkOutput("reset sel",   16'(bus.mem_sel),   16'h0);
        checkOutput("reset mem_w", 16'(bus.mem_w),     16'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: DMA read with CPU idle, ack two cycles after the request is seen
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h5678, 1, 0, 16'h0);
        checkOutput("t1 c0 ack",   16'(bus.dma_ack),   16'h0);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h5678, 1, 0, 16'h0);
        checkOutput("t1 dma addr", bus.mem_addr,       16'h5678);
        checkOutput("t1 dma r",    16'(bus.mem_r),     16'h1);
        checkOutput("t1 c1 stall", 16'(bus.cpu_stall), 16'h0);
        checkOutput("t1 c1 ack",   16'(bus.dma_ack),   16'h0);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h5678, 0, 0, 16'h0);
        checkOutput("t1 c2 ack",   16'(bus.dma_ack),   16'h1);
        checkOutput("t1 din",      bus.dma_din,        16'h1234);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0000, 0, 0, 16'h0);
        checkOutput("t1 c3 ack",   16'(bus.dma_ack),   16'h0);

        // 2: DMA write, request held into the ACK cycle must not write twice
        wc0 = write_count;
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0010, 0, 1, 16'hBEEF);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0010, 0, 1, 16'hBEEF);
        checkOutput("t2 mem_w",    16'(bus.mem_w),     16'h3);
        checkOutput("t2 addr",     bus.mem_addr,       16'h0010);
        checkOutput("t2 wdata",    bus.mem_wdata,      16'hBEEF);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0010, 0, 1, 16'hBEEF);
        checkOutput("t2 ack",      16'(bus.dma_ack),   16'h1);
        checkOutput("t2 ack mem_w", 16'(bus.mem_w),    16'h0);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0000, 0, 0, 16'h0);
        checkOutput("t2 ack gone", 16'(bus.dma_ack),   16'h0);
        checkOutput("t2 writes",   16'(write_count - wc0), 16'h1);
        checkOutput("t2 mem",      mem[15'h0008],      16'hBEEF);

        // 3: CPU reads every cycle; DMA wins only after eight lost cycles
        for (int k = 0; k < 9; k++) begin
            applyStimulus(16'h0100, 1, 2'b00, 16'h0, 16'h2000, 1, 0, 16'h0);
            checkOutput($sformatf("t3 wait%0d stall", k), 16'(bus.cpu_stall), 16'h0);
            checkOutput($sformatf("t3 wait%0d addr", k),  bus.mem_addr,       16'h0100);
        end
        applyStimulus(16'h0100, 1, 2'b00, 16'h0, 16'h2000, 1, 0, 16'h0);
        checkOutput("t3 grant stall", 16'(bus.cpu_stall), 16'h1);
        checkOutput("t3 grant addr",  bus.mem_addr,       16'h2000);
        applyStimulus(16'h0100, 1, 2'b00, 16'h0, 16'h2000, 0, 0, 16'h0);
        checkOutput("t3 ack",         16'(bus.dma_ack),   16'h1);
        checkOutput("t3 ack stall",   16'(bus.cpu_stall), 16'h0);
        checkOutput("t3 din",         bus.dma_din,        16'h7777);
        checkOutput("t3 cpu rdata",   bus.mem_rdata,      16'hCAFE);

        // 4: CPU IO-window write does not hold off DMA
        applyStimulus(16'hFFF8, 0, 2'b11, 16'h1111, 16'h0040, 0, 1, 16'h4444);
        checkOutput("t4 io sel",   16'(bus.mem_sel),   16'h0);
        checkOutput("t4 io stall", 16'(bus.cpu_stall), 16'h0);
        applyStimulus(16'hFFF8, 0, 2'b11, 16'h1111, 16'h0040, 0, 1, 16'h4444);
        checkOutput("t4 dma stall", 16'(bus.cpu_stall), 16'h0);
        checkOutput("t4 dma mem_w", 16'(bus.mem_w),     16'h3);
        checkOutput("t4 dma addr",  bus.mem_addr,       16'h0040);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0000, 0, 0, 16'h0);
        checkOutput("t4 ack",      16'(bus.dma_ack),   16'h1);
        checkOutput("t4 mem",      mem[15'h0020],      16'h4444);
        checkOutput("t4 io mem",   mem[15'h7FFC],      16'h0000);

        // 5: read and write requested together are served as one write
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0061, 1, 1, 16'h5555);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0061, 1, 1, 16'h5555);
        checkOutput("t5 mem_w",    16'(bus.mem_w),     16'h3);
        checkOutput("t5 mem_r",    16'(bus.mem_r),     16'h0);
        checkOutput("t5 addr",     bus.mem_addr,       16'h0060);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0000, 0, 0, 16'h0);
        checkOutput("t5 ack",      16'(bus.dma_ack),   16'h1);
        checkOutput("t5 din",      bus.dma_din,        16'h7777);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0000, 0, 0, 16'h0);
        checkOutput("t5 ack once", 16'(bus.dma_ack),   16'h0);
        checkOutput("t5 mem",      mem[15'h0030],      16'h5555);

        // 6: reset in the middle of a DMA write abandons it cleanly
        wc0 = write_count;
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h00A0, 0, 1, 16'h6666);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h00A0, 0, 1, 16'h6666);
        checkOutput("t6 pre mem_w", 16'(bus.mem_w),    16'h3);
        reset = 1'b1;
        #1;
        checkOutput("t6 rst mem_w", 16'(bus.mem_w),    16'h0);
        checkOutput("t6 rst sel",   16'(bus.mem_sel),  16'h0);
        checkOutput("t6 rst ack",   16'(bus.dma_ack),  16'h0);
        @(posedge clk);
        #1;
        checkOutput("t6 rst ack2",   16'(bus.dma_ack), 16'h0);
        checkOutput("t6 no write",   16'(write_count - wc0), 16'h0);
        checkOutput("t6 mem intact", mem[15'h0050],    16'h0000);
        reset = 1'b0;
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h00A0, 0, 1, 16'h6666);
        checkOutput("t6 redo mem_w", 16'(bus.mem_w),   16'h3);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0000, 0, 0, 16'h0);
        checkOutput("t6 redo ack",   16'(bus.dma_ack), 16'h1);
        applyStimulus(16'h0000, 0, 2'b00, 16'h0, 16'h0000, 0, 0, 16'h0);
        checkOutput("t6 redo mem",   mem[15'h0050],    16'h6666);
        checkOutput("t6 writes",     16'(write_count - wc0), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
